ifq_fetch: RTL and testbench
============================

Name: ifq_fetch

Overview:
- Instruction fetch front end with a small prefetch queue.
- Drives instruction addresses into the synchronous unified memory and captures the returned words.
- Presents pc/instr pairs to the decode stage with a valid/stall handshake.
- Absorbs decode back-pressure and squashes wrong-path fetches on a redirect from execute.

Parameters:
- SIZE_ADDR, 24, address/PC width.
- SIZE_DATA, 24, instruction word width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset, asynchronous, active-high.
- ow_mem_addr  out  SIZE_ADDR  fetch address; the memory registers rdata for this address on the next edge.
- iw_mem_rdata  in  SIZE_DATA  word for the address issued in the previous cycle.
- iw_redirect  in  1  flush and restart fetch.
- iw_redirect_pc  in  SIZE_ADDR  restart address.
- iw_stall  in  1  decode not accepting this cycle.
- ow_valid  out  1  ow_pc/ow_instr hold a valid entry.
- ow_pc  out  SIZE_ADDR  PC of the head entry.
- ow_instr  out  SIZE_DATA  instruction of the head entry.

Behaviour:
- Reset: r_pc=RESET_PC, queue empty, r_inflight=0, ow_valid=0, ow_pc=0, ow_instr=0. ow_mem_addr=RESET_PC. Reset mid-operation discards all entries immediately.
- ow_mem_addr = r_pc, driven combinationally from the register.
- Issue rule: issue when !iw_redirect && (count + r_inflight) < DEPTH. Pops in the same cycle are not credited.
- On issue: r_pc <= r_pc + 1, wrapping modulo 2^SIZE_ADDR; r_inflight <= 1; r_inflight_pc <= r_pc.
- When not issuing: r_pc holds and r_inflight <= 0.
- Capture: when r_inflight=1 and there is no redirect, push {r_inflight_pc, iw_mem_rdata} at the tail. Overflow is impossible by the issue rule; the bench asserts this.
- Pop: when ow_valid && !iw_stall, the head advances. Push and pop in the same cycle leave count unchanged.
- Outputs are taken from the head entry. ow_valid = (count != 0). When empty, ow_pc and ow_instr hold their last values.
- Latency: issue in cycle N, rdata visible in N+1 and pushed at the end of N+1, so ow_valid=1 in N+2.
- Redirect in cycle N, highest priority:
  - queue flushed (count=0) and r_inflight cleared, so the returning word is dropped;
  - r_pc <= iw_redirect_pc; no issue in N; a pop in N is ignored;
  - issue of iw_redirect_pc in N+1, ow_valid in N+3.
- Redirect repeated on consecutive cycles: the last one wins.
- Full queue with iw_stall held: issue stops, ow_mem_addr holds, no entry is lost or duplicated.
- Head/tail pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined: if the queue is empty and a capture occurs, the captured word drives ow_valid/ow_pc/ow_instr combinationally in the same cycle.
  - If not stalled, it is consumed and not pushed; if stalled, it is pushed.
  - Latency becomes issue N, valid N+1. Post-redirect valid becomes N+2.
- When undefined: outputs come only from the queue, with the latencies given above.

Decomposition:
- Shared size header holds SIZE_ADDR/SIZE_DATA and HBIT_ macros plus RESET_PC; reused by the pipeline stages.
- Sub-module ifq_fifo: circular buffer with push, pop, flush, count, head data, parameterised on DEPTH and entry width.
- ifq_fetch itself holds the PC, in-flight tracking and redirect control.

Test Plan:
- Reset release with iw_stall=0 and memory word k = 0x100+k: ow_mem_addr is 0,1,2…; first ow_valid in cycle 2 with pc 0 / instr 0x100. Thereafter one instruction per cycle, in order.
- iw_stall=1 from cycle 0: count reaches 4 and ow_mem_addr freezes at 4. On release, pcs 0,1,2,3,4… are delivered with no gaps or duplicates.
- Redirect to 0x40 in steady state: the in-flight word and queued entries never appear. ow_valid low for 2 cycles, then pc 0x40, 0x41…
- Redirect asserted while the queue is full and a pop is attempted: the head is not consumed, the flush completes, and the first output after the flush is redirect_pc.
- Redirect to 0xFFFFFE: pcs delivered are 0xFFFFFE, 0xFFFFFF, 0x000000 (wrap).
- iw_rst pulsed mid-stream with the queue holding 3 entries: ow_valid=0 immediately, and the sequence restarts from RESET_PC. With IFQ_BYPASS_EN, first valid appears in cycle 1.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared sizing constants for the instruction-fetch pipeline stages.
// Reused by the fetch front end and its prefetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_SIZE_ADDR = 24;
    localparam int unsigned IFQ_SIZE_DATA = 24;
    localparam int unsigned IFQ_DEPTH     = 4;
    localparam int unsigned IFQ_RESET_PC  = 0;

endpackage

// File: rtl/ifq_fifo.sv
// Circular prefetch buffer: push at tail, pop at head, single-cycle flush.
// Head entry is presented combinationally; count distinguishes empty from full.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_flush,
    input  logic                     iw_push,
    input  logic [WIDTH-1:0]         iw_push_data,
    input  logic                     iw_pop,
    output logic [$clog2(DEPTH):0]   ow_count,
    output logic [WIDTH-1:0]         ow_head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    // NOTE: the storage array is deliberately not reset; r_count alone says which slots are live.
    always_ff @(posedge iw_clk) begin
        if (iw_push && !iw_flush) begin
            mem[r_tail] <= iw_push_data;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (iw_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (iw_push) r_tail <= r_tail + 1'b1;
            if (iw_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + (PW+1)'(iw_push) - (PW+1)'(iw_pop);
        end
    end

    assign ow_count = r_count;
    assign ow_head  = mem[r_head];

endmodule

// File: rtl/ifq_fetch.sv
// Instruction fetch front end: PC, one-deep in-flight tracking, redirect squash, prefetch queue.
// Define IFQ_BYPASS_EN to let a word captured into an empty queue reach decode in the same cycle.
module ifq_fetch
    import ifq_pkg::*;
#(
    parameter int                       SIZE_ADDR = IFQ_SIZE_ADDR,
    parameter int                       SIZE_DATA = IFQ_SIZE_DATA,
    parameter int                       DEPTH     = IFQ_DEPTH,
    parameter logic [SIZE_ADDR-1:0]     RESET_PC  = SIZE_ADDR'(IFQ_RESET_PC)
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    output logic [SIZE_ADDR-1:0] ow_mem_addr,
    input  logic [SIZE_DATA-1:0] iw_mem_rdata,
    input  logic                 iw_redirect,
    input  logic [SIZE_ADDR-1:0] iw_redirect_pc,
    input  logic                 iw_stall,
    output logic                 ow_valid,
    output logic [SIZE_ADDR-1:0] ow_pc,
    output logic [SIZE_DATA-1:0] ow_instr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = SIZE_ADDR + SIZE_DATA;

    logic [SIZE_ADDR-1:0] r_pc;
    logic [SIZE_ADDR-1:0] r_inflight_pc;
    logic                 r_inflight;
    logic [EW-1:0]        r_last;

    logic [CW-1:0]        count;
    logic [EW-1:0]        head;
    logic [EW-1:0]        cap_entry;
    logic [EW-1:0]        out_entry;
    logic                 issue, capture, push, pop, fifo_valid;

    // Credit the in-flight word against the queue so a capture can never overflow it.
    assign issue      = !iw_redirect && ((int'(count) + int'(r_inflight)) < DEPTH);
    assign capture    = r_inflight && !iw_redirect;
    assign fifo_valid = (count != '0);
    assign cap_entry  = {r_inflight_pc, iw_mem_rdata};
    assign pop        = fifo_valid && !iw_stall && !iw_redirect;

    // NOTE: always_comb uses blocking assignments; always_ff uses non-blocking so flops update together.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        ow_valid  = fifo_valid;
        out_entry = fifo_valid ? head : r_last;
        push      = capture;
`ifdef IFQ_BYPASS_EN
        if (capture && !fifo_valid) begin
            ow_valid  = 1'b1;
            out_entry = cap_entry;
            push      = iw_stall;
        end
`endif
    end

    assign {ow_pc, ow_instr} = out_entry;
    assign ow_mem_addr       = r_pc;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (iw_redirect) begin
            r_pc       <= iw_redirect_pc;
            r_inflight <= 1'b0;
        end else if (issue) begin
            r_pc          <= r_pc + 1'b1;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Keeps the last presented pair on the outputs while the queue is empty.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_last <= '0;
        end else if (ow_valid) begin
            r_last <= out_entry;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_flush     (iw_redirect),
        .iw_push      (push),
        .iw_push_data (cap_entry),
        .iw_pop       (pop),
        .ow_count     (count),
        .ow_head      (head)
    );

endmodule

// File: tb/tb_ifq_fetch.sv
// Self-checking bench for ifq_fetch: queue-based reference model plus directed and random stimulus.
// Build with IFQ_BYPASS_EN defined to check the bypass variant.
module tb_ifq_fetch;

    localparam int          SA    = 24;
    localparam int          SD    = 24;
    localparam int          DEPTH = 4;
    localparam logic [23:0] RPC   = 24'h000000;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          iw_clk = 1'b0;
    logic          iw_rst = 1'b1;
    logic [SA-1:0] ow_mem_addr;
    logic [SD-1:0] iw_mem_rdata;
    logic          iw_redirect = 1'b0;
    logic [SA-1:0] iw_redirect_pc = '0;
    logic          iw_stall = 1'b0;
    logic          ow_valid;
    logic [SA-1:0] ow_pc;
    logic [SD-1:0] ow_instr;

    ifq_fetch #(
        .SIZE_ADDR (SA),
        .SIZE_DATA (SD),
        .DEPTH     (DEPTH),
        .RESET_PC  (RPC)
    ) dut (
        .iw_clk         (iw_clk),
        .iw_rst         (iw_rst),
        .ow_mem_addr    (ow_mem_addr),
        .iw_mem_rdata   (iw_mem_rdata),
        .iw_redirect    (iw_redirect),
        .iw_redirect_pc (iw_redirect_pc),
        .iw_stall       (iw_stall),
        .ow_valid       (ow_valid),
        .ow_pc          (ow_pc),
        .ow_instr       (ow_instr)
    );

    always #5 iw_clk = ~iw_clk;

    function automatic logic [SD-1:0] word(input logic [SA-1:0] a);
        return a + 24'h100;
    endfunction

    // Synchronous memory: word for the address seen at this edge appears next cycle.
    always @(posedge iw_clk) iw_mem_rdata <= word(ow_mem_addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [SA-1:0] pc;
        logic [SD-1:0] instr;
    } ent_t;

    ent_t          q[$];
    logic [SA-1:0] m_pc;
    logic [SA-1:0] m_ipc;
    bit            m_inflight;
    ent_t          m_last;
    ent_t          m_exp;
    ent_t          m_capt;
    bit            m_ev;
    bit            m_cap;
    bit            m_byp;
    int            m_cnt;

    // Reference model: checks outputs at each falling edge, then advances to the next rising edge.
    always @(negedge iw_clk) begin
        if (iw_rst) begin
            q.delete();
            m_pc       = RPC;
            m_inflight = 1'b0;
            m_last     = '0;
            check("rst_valid", ow_valid, 0);
            check("rst_pc", ow_pc, 0);
            check("rst_instr", ow_instr, 0);
            check("rst_addr", ow_mem_addr, RPC);
        end else begin
            m_cnt  = q.size();
            m_cap  = m_inflight && !iw_redirect;
            m_capt = '{pc: m_ipc, instr: word(m_ipc)};
            m_ev   = (m_cnt != 0);
            m_exp  = m_ev ? q[0] : m_last;
            m_byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
            if (m_cnt == 0 && m_cap) begin
                m_byp = 1'b1;
                m_ev  = 1'b1;
                m_exp = m_capt;
            end
`endif
            check("mem_addr", ow_mem_addr, m_pc);
            check("valid", ow_valid, m_ev);
            check("pc", ow_pc, m_exp.pc);
            check("instr", ow_instr, m_exp.instr);
            if (m_ev) m_last = m_exp;

            if (iw_redirect) begin
                q.delete();
                m_inflight = 1'b0;
                m_pc       = iw_redirect_pc;
            end else begin
                if (m_byp) begin
                    if (iw_stall) q.push_back(m_capt);
                end else begin
                    if (m_ev && !iw_stall) void'(q.pop_front());
                    if (m_cap) q.push_back(m_capt);
                end
                check("no_overflow", q.size() <= DEPTH, 1);
                if (m_cnt + int'(m_inflight) < DEPTH) begin
                    m_ipc      = m_pc;
                    m_pc       = m_pc + 1'b1;
                    m_inflight = 1'b1;
                end else begin
                    m_inflight = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge iw_clk);
    endtask

    task automatic do_reset();
        iw_rst      = 1'b1;
        iw_redirect = 1'b0;
        iw_stall    = 1'b0;
        tick();
        iw_rst = 1'b0;
    endtask

    // Redirect for one cycle, then expect LAT idle cycles followed by n sequential pcs.
    task automatic redir_check(input string name, input logic [SA-1:0] rpc, input int n);
        logic [SA-1:0] exp_pc;
        iw_redirect    = 1'b1;
        iw_redirect_pc = rpc;
        iw_stall       = 1'b0;
        tick();
        iw_redirect = 1'b0;
        exp_pc      = rpc;
        for (int k = 1; k <= LAT + n; k++) begin
            at_neg();
            if (k <= LAT) begin
                check({name, "_idle"}, ow_valid, 0);
            end else begin
                check({name, "_valid"}, ow_valid, 1);
                check({name, "_pc"}, ow_pc, exp_pc);
                exp_pc = exp_pc + 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        // Reset release and first-fetch latency.
        do_reset();
        at_neg();
        check("t1_addr0", ow_mem_addr, 0);
        check("t1_valid0", ow_valid, 0);
        repeat (LAT) tick();
        at_neg();
        check("t1_first_valid", ow_valid, 1);
        check("t1_first_pc", ow_pc, 0);
        check("t1_first_instr", ow_instr, 24'h100);
        repeat (10) tick();

        // Stall from cycle 0 fills the queue and freezes the fetch address.
        do_reset();
        iw_stall = 1'b1;
        repeat (6) tick();
        at_neg();
        check("t2_addr_frozen", ow_mem_addr, 4);
        check("t2_head_pc", ow_pc, 0);
        tick();
        iw_stall = 1'b0;
        repeat (20) tick();

        // Steady-state redirect.
        redir_check("t3", 24'h000040, 3);

        // Redirect while full with a pop attempted.
        iw_stall = 1'b1;
        repeat (6) tick();
        redir_check("t4", 24'h000080, 2);

        // PC wrap.
        redir_check("t5", 24'hFFFFFE, 3);
        repeat (4) tick();

        // Mid-stream reset with three entries queued.
        do_reset();
        iw_stall = 1'b1;
        repeat (4) tick();
        check("t6_pre_valid", ow_valid, 1);
        #2;
        iw_rst = 1'b1;
        #1;
        check("t6_rst_valid", ow_valid, 0);
        check("t6_rst_addr", ow_mem_addr, RPC);
        tick();
        iw_rst   = 1'b0;
        iw_stall = 1'b0;
        repeat (LAT) tick();
        at_neg();
        check("t6_restart_valid", ow_valid, 1);
        check("t6_restart_pc", ow_pc, RPC);
        tick();

        // Random stall/redirect traffic, including redirects near the wrap point.
        for (int i = 0; i < 1000; i++) begin
            iw_stall    = ($urandom % 4) == 0;
            iw_redirect = ($urandom % 25) == 0;
            if (($urandom % 3) == 0) iw_redirect_pc = 24'hFFFFFC + 24'($urandom % 4);
            else                     iw_redirect_pc = 24'($urandom);
            tick();
        end
        iw_redirect = 1'b0;
        iw_stall    = 1'b0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
